// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : game_sequencer
// Purpose : whack-a-mole play controller: start/play/over sequencing, mole
//           windows, scoring, misses and game clock. GAME_PAUSE_EN: abort pauses.
// Rev     : 1.0
// ============================================================================
module game_sequencer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int GAME_SECS   = 30,
    parameter int MOLE_CYCLES = 75_000_000,
    parameter int MAX_MISS    = 3,
    parameter int SCORE_W     = 8,
    parameter int TIME_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [4:0]         hit,
    input  logic [2:0]         hole_in,
    output logic               hole_req,
    output logic               mole_valid,
    output logic [2:0]         mole_hole,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         misses,
    output logic [TIME_W-1:0]  time_left,
    output logic [1:0]         screen_sel,
    output logic               game_over,
    output logic               paused
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MOLE_W = (MOLE_CYCLES > 1) ? $clog2(MOLE_CYCLES) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [MOLE_W-1:0]  MOLE_LAST = MOLE_W'(MOLE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [TIME_W-1:0]  TIME_INIT = TIME_W'(GAME_SECS);
    localparam logic [1:0]         MISS_END  = 2'(MAX_MISS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_UP   = 2'b11,
        ST_OVER = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [1:0]         misses_q, misses_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [MOLE_W-1:0]  mole_cnt_q, mole_cnt_d;
    logic [2:0]         mole_hole_q, mole_hole_d;
    logic               game_over_q, game_over_d;

    logic               start_prev_q, abort_prev_q;
    logic [4:0]         hit_prev_q;
    logic               start_press, abort_press;
    logic [4:0]         hit_press;
    logic               correct_hit;
    logic               tick, miss, game_end;

`ifdef GAME_PAUSE_EN
    logic               paused_q, paused_d;
`endif

    assign start_press = start & ~start_prev_q;
    assign abort_press = abort & ~abort_prev_q;
    assign hit_press   = hit & ~hit_prev_q;

    always_comb begin
        correct_hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (mole_hole_q == 3'(i)) correct_hit = hit_press[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        misses_d    = misses_q;
        time_d      = time_q;
        pre_d       = pre_q;
        mole_cnt_d  = mole_cnt_q;
        mole_hole_d = mole_hole_q;
        tick        = 1'b0;
        miss        = 1'b0;
        game_end    = 1'b0;
`ifdef GAME_PAUSE_EN
        paused_d    = paused_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d  = ST_REQ;
                    score_d  = '0;
                    misses_d = '0;
                    time_d   = TIME_INIT;
                    pre_d    = '0;
                end
            end
            ST_REQ, ST_UP: begin
`ifdef GAME_PAUSE_EN
                if (abort_press) paused_d = ~paused_q;
                if (!paused_q) begin
`else
                if (abort_press) begin
                    state_d = ST_IDLE;
                end else begin
`endif
                    tick  = (pre_q == PRE_LAST);
                    pre_d = tick ? '0 : pre_q + PRE_W'(1);
                    if (tick) time_d = time_q - TIME_W'(1);
                    if (state_q == ST_REQ) begin
                        if (hole_in <= 3'd4) begin
                            mole_hole_d = hole_in;
                            mole_cnt_d  = '0;
                            state_d     = ST_UP;
                        end
                    end else if (correct_hit) begin
                        // A hit in the expiry cycle takes precedence over the miss.
                        if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
                        state_d = ST_REQ;
                    end else if (mole_cnt_q == MOLE_LAST) begin
                        miss     = 1'b1;
                        misses_d = misses_q + 2'd1;
                        state_d  = ST_REQ;
                    end else begin
                        mole_cnt_d = mole_cnt_q + MOLE_W'(1);
                    end
                    game_end = (tick && (time_d == '0)) || (miss && (misses_d == MISS_END));
                    if (game_end) state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (start_press) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef GAME_PAUSE_EN
        if ((state_d != ST_REQ) && (state_d != ST_UP)) paused_d = 1'b0;
`endif
    end

    assign game_over_d = (state_d == ST_OVER) && (state_q != ST_OVER);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            score_q      <= '0;
            misses_q     <= '0;
            time_q       <= TIME_INIT;
            pre_q        <= '0;
            mole_cnt_q   <= '0;
            mole_hole_q  <= '0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b0;
            abort_prev_q <= 1'b0;
            hit_prev_q   <= '0;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            time_q       <= time_d;
            pre_q        <= pre_d;
            mole_cnt_q   <= mole_cnt_d;
            mole_hole_q  <= mole_hole_d;
            game_over_q  <= game_over_d;
            start_prev_q <= start;
            abort_prev_q <= abort;
            hit_prev_q   <= hit;
        end
    end

`ifdef GAME_PAUSE_EN
    always_ff @(posedge clk) begin
        if (!rst) paused_q <= 1'b0;
        else      paused_q <= paused_d;
    end

    assign paused   = paused_q;
    assign hole_req = (state_q == ST_REQ) && !paused_q;
`else
    assign paused   = 1'b0;
    assign hole_req = (state_q == ST_REQ);
`endif

    assign mole_valid = (state_q == ST_UP);
    assign mole_hole  = mole_hole_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign time_left  = time_q;
    assign game_over  = game_over_q;
    assign screen_sel = (state_q == ST_OVER) ? 2'b10 :
                        (state_q == ST_IDLE) ? 2'b00 : 2'b01;

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// Bench for game_sequencer: two instances (3 s and 10 s games) on shared stimulus,
// compared every cycle against a rule-level model, plus literal spot checks.
module tb_game_sequencer;

    localparam int TB_TICK = 4;
    localparam int TB_MOLE = 10;
    localparam int TB_MAXM = 3;
    localparam int SMAX    = 255;
    localparam int P_IDLE = 0, P_REQ = 1, P_UP = 2, P_OVER = 3;

    typedef struct packed {
        int       phase;
        int       score;
        int       misses;
        int       tleft;
        int       active;
        int       age;
        int       hole;
        bit       paused;
        bit       pulse;
        bit       ps;
        bit       pa;
        bit [4:0] ph;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] hit = '0;
    logic [2:0] hole_in = '0;

    logic       a_hr, a_mv, a_go, a_pa, b_hr, b_mv, b_go, b_pa;
    logic [2:0] a_mh, b_mh;
    logic [7:0] a_sc, b_sc;
    logic [1:0] a_mi, b_mi, a_ss, b_ss;
    logic [5:0] a_tl, b_tl;

    int   n_err = 0;
    int   n_checks = 0;
    bit   chk_en = 1'b0;
    mdl_t ma, mb;

    always #5 clk = ~clk;

    game_sequencer #(.TICK_DIV(TB_TICK), .GAME_SECS(3), .MOLE_CYCLES(TB_MOLE),
                     .MAX_MISS(TB_MAXM), .SCORE_W(8), .TIME_W(6)) dut_a (
        .clk(clk), .rst(rst_n), .start(start), .abort(abort), .hit(hit), .hole_in(hole_in),
        .hole_req(a_hr), .mole_valid(a_mv), .mole_hole(a_mh), .score(a_sc), .misses(a_mi),
        .time_left(a_tl), .screen_sel(a_ss), .game_over(a_go), .paused(a_pa));

    game_sequencer #(.TICK_DIV(TB_TICK), .GAME_SECS(10), .MOLE_CYCLES(TB_MOLE),
                     .MAX_MISS(TB_MAXM), .SCORE_W(8), .TIME_W(6)) dut_b (
        .clk(clk), .rst(rst_n), .start(start), .abort(abort), .hit(hit), .hole_in(hole_in),
        .hole_req(b_hr), .mole_valid(b_mv), .mole_hole(b_mh), .score(b_sc), .misses(b_mi),
        .time_left(b_tl), .screen_sel(b_ss), .game_over(b_go), .paused(b_pa));

    function automatic mdl_t mreset(int secs);
        mdl_t r;
        r = '0;
        r.phase = P_IDLE;
        r.tleft = secs;
        return r;
    endfunction

    // One clock of the game rules, applied to the inputs seen at the edge.
    function automatic mdl_t mstep(mdl_t m, bit st, bit ab, bit [4:0] h, bit [2:0] hin,
                                   bit do_rst, int secs);
        mdl_t     n;
        bit       sp, ap, ended;
        bit [4:0] hp;
        if (do_rst) return mreset(secs);
        n = m;
        sp = st & ~m.ps;
        ap = ab & ~m.pa;
        hp = h & ~m.ph;
        n.ps = st;
        n.pa = ab;
        n.ph = h;
        n.pulse = 1'b0;
        ended = 1'b0;
        if (m.phase == P_IDLE) begin
            if (sp) begin
                n.phase = P_REQ; n.score = 0; n.misses = 0; n.tleft = secs; n.active = 0;
            end
        end else if (m.phase == P_OVER) begin
            if (sp) n.phase = P_IDLE;
        end else begin
`ifdef GAME_PAUSE_EN
            if (ap) n.paused = !m.paused;
            if (!m.paused) begin
`else
            if (ap) begin
                n.phase = P_IDLE;
            end else begin
`endif
                n.active = m.active + 1;
                if (n.active % TB_TICK == 0) begin
                    n.tleft = n.tleft - 1;
                    ended = (n.tleft == 0);
                end
                if (m.phase == P_REQ) begin
                    if (hin <= 4) begin
                        n.hole = int'(hin); n.age = 0; n.phase = P_UP;
                    end
                end else if (hp[m.hole]) begin
                    n.score = (m.score < SMAX) ? m.score + 1 : SMAX;
                    n.phase = P_REQ;
                end else if (m.age + 1 == TB_MOLE) begin
                    n.misses = m.misses + 1;
                    n.phase = P_REQ;
                    if (n.misses == TB_MAXM) ended = 1'b1;
                end else begin
                    n.age = m.age + 1;
                end
                if (ended) begin
                    n.phase = P_OVER; n.pulse = 1'b1;
                end
            end
            if (n.phase != P_REQ && n.phase != P_UP) n.paused = 1'b0;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input logic hr, input logic mv, input logic [2:0] mh,
                           input logic [7:0] sc, input logic [1:0] mi, input logic [5:0] tl,
                           input logic [1:0] ss, input logic go, input logic pa, input mdl_t m);
        int ess;
        ess = (m.phase == P_IDLE) ? 0 : (m.phase == P_OVER) ? 2 : 1;
        chk({tag, ".hole_req"},   int'(hr), int'(m.phase == P_REQ && !m.paused));
        chk({tag, ".mole_valid"}, int'(mv), int'(m.phase == P_UP));
        chk({tag, ".mole_hole"},  int'(mh), m.hole);
        chk({tag, ".score"},      int'(sc), m.score);
        chk({tag, ".misses"},     int'(mi), m.misses);
        chk({tag, ".time_left"},  int'(tl), m.tleft);
        chk({tag, ".screen_sel"}, int'(ss), ess);
        chk({tag, ".game_over"},  int'(go), int'(m.pulse));
        chk({tag, ".paused"},     int'(pa), int'(m.paused));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_all("a", a_hr, a_mv, a_mh, a_sc, a_mi, a_tl, a_ss, a_go, a_pa, ma);
            cmp_all("b", b_hr, b_mv, b_mh, b_sc, b_mi, b_tl, b_ss, b_go, b_pa, mb);
        end
    end

    task automatic cyc();
        @(posedge clk);
        ma = mstep(ma, start, abort, hit, hole_in, !rst_n, 3);
        mb = mstep(mb, start, abort, hit, hole_in, !rst_n, 10);
        chk_en = 1'b1;
        #2;
    endtask

    initial begin
        ma = mreset(3);
        mb = mreset(10);
        cyc(); cyc();
        chk("lit reset a.screen_sel", int'(a_ss), 0);
        chk("lit reset a.time_left", int'(a_tl), 3);
        chk("lit reset b.time_left", int'(b_tl), 10);
        chk("lit reset a.mole_valid", int'(a_mv), 0);
        rst_n = 1'b1; cyc();
        start = 1'b1; hole_in = 3'd2; cyc();
        chk("lit start a.screen_sel", int'(a_ss), 1);
        chk("lit start a.hole_req", int'(a_hr), 1);
        start = 1'b0; cyc();
        chk("lit up a.mole_valid", int'(a_mv), 1);
        chk("lit up a.mole_hole", int'(a_mh), 2);
        chk("lit up a.hole_req", int'(a_hr), 0);
        hit = 5'b00100; cyc();
        chk("lit hit a.score", int'(a_sc), 1);
        chk("lit hit a.hole_req", int'(a_hr), 1);
        repeat (19) cyc();
        chk("lit held a.score", int'(a_sc), 1);
        chk("lit held a.screen_sel", int'(a_ss), 2);
        chk("lit held a.time_left", int'(a_tl), 0);
        chk("lit held b.score", int'(b_sc), 1);
        chk("lit held b.misses", int'(b_mi), 1);
        chk("lit held b.time_left", int'(b_tl), 5);
        hit = 5'b0; repeat (14) cyc();
        chk("lit 3miss b.misses", int'(b_mi), 3);
        chk("lit 3miss b.screen_sel", int'(b_ss), 2);
        chk("lit 3miss b.game_over", int'(b_go), 1);
        chk("lit 3miss b.time_left", int'(b_tl), 2);
        cyc();
        chk("lit over b.game_over", int'(b_go), 0);
        chk("lit over b.mole_valid", int'(b_mv), 0);
        start = 1'b1; cyc();
        chk("lit idle a.screen_sel", int'(a_ss), 0);
        chk("lit idle a.score kept", int'(a_sc), 1);
        start = 1'b0; cyc();
        start = 1'b1; hole_in = 3'd1; cyc();
        chk("lit restart a.score", int'(a_sc), 0);
        chk("lit restart a.time_left", int'(a_tl), 3);
        start = 1'b0; repeat (11) cyc();
        chk("lit expiry a.misses", int'(a_mi), 1);
        chk("lit expiry a.time_left", int'(a_tl), 1);
        cyc();
        chk("lit timeout a.game_over", int'(a_go), 1);
        chk("lit timeout a.screen_sel", int'(a_ss), 2);
        chk("lit timeout a.time_left", int'(a_tl), 0);
        abort = 1'b1; cyc();
        chk("lit abort b.time_left", int'(b_tl), 7);
`ifdef GAME_PAUSE_EN
        chk("lit abort b.paused", int'(b_pa), 1);
        abort = 1'b0; repeat (50) cyc();
        chk("lit frozen b.time_left", int'(b_tl), 7);
        chk("lit frozen b.mole_valid", int'(b_mv), 1);
        chk("lit frozen b.hole_req", int'(b_hr), 0);
        abort = 1'b1; cyc();
        abort = 1'b0; cyc();
        chk("lit resume b.paused", int'(b_pa), 0);
`else
        chk("lit abort b.screen_sel", int'(b_ss), 0);
        chk("lit abort b.mole_valid", int'(b_mv), 0);
        chk("lit abort b.misses", int'(b_mi), 1);
        abort = 1'b0; cyc();
`endif
        rst_n = 1'b0; cyc();
        chk("lit midreset b.screen_sel", int'(b_ss), 0);
        chk("lit midreset b.time_left", int'(b_tl), 10);
        rst_n = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) start = ~start;
            abort = ($urandom_range(0, 59) == 0);
            if ((k % 400) < 200) hit = 5'($urandom);
            else hit = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'b0;
            hole_in = 3'($urandom_range(0, 7));
            cyc();
        end
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
